// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: address width, control-flow opcodes,
// and the fetch state encoding.
package fetch_unit_pkg;

  localparam int ADDR_W = 4;
  localparam int INST_W = 16;

  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;

  typedef enum logic {
    FETCH   = 1'b0,
    WAIT_BR = 1'b1
  } fetch_state_t;

  // Opcode field of an instruction word.
  function automatic logic [3:0] inst_opcode(input logic [INST_W-1:0] inst);
    return inst[15:12];
  endfunction

  // Branch/jump target field of an instruction word.
  function automatic logic [ADDR_W-1:0] inst_target(input logic [INST_W-1:0] inst);
    return inst[11:8];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Folds jmp in place, forwards br to decode and
// stalls until execute resolves it, and hands instructions to decode via a
// valid/ready handshake with one-cycle latency.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 4'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              br_resolved,
  input  logic              br_taken,
  output logic              fetch_stall
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] br_fall;

  logic              fetch_en;
  logic              accept;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  assign rom_addr = pc;
  assign opcode   = inst_opcode(rom_data);
  assign target   = inst_target(rom_data);
  assign pc_inc   = pc + 1'b1;  // 4-bit add wraps 15 -> 0

  // A fetch may happen only when the output slot is empty or being drained.
  assign accept   = inst_valid && inst_ready;
  assign fetch_en = (state == FETCH) && (!inst_valid || inst_ready);

  // PC, output slot, branch bookkeeping and FSM state.
  // NOTE: every register here, including the branch latches, is reset so a
  // reset in WAIT_BR leaves no stale branch behind; non-blocking assignments
  // keep all updates in this block using pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inst_out    <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      br_target   <= '0;
      br_fall     <= '0;
      fetch_stall <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // br_resolved is deliberately ignored here.
          if (fetch_en) begin
            case (opcode)
              OP_JMP: begin
                // Folded: redirect and emit nothing; the slot drains if accepted.
                pc         <= target;
                inst_valid <= 1'b0;
              end
              OP_BR: begin
                inst_out    <= rom_data;
                inst_pc     <= pc;
                inst_valid  <= 1'b1;
                br_target   <= target;
                br_fall     <= pc_inc;
                state       <= WAIT_BR;
                fetch_stall <= 1'b1;
              end
              default: begin
                inst_out   <= rom_data;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                pc         <= pc_inc;
              end
            endcase
          end
        end
        WAIT_BR: begin
          // The forwarded br drains independently of resolution.
          if (accept) begin
            inst_valid <= 1'b0;
          end
          if (br_resolved) begin
            pc          <= br_taken ? br_target : br_fall;
            state       <= FETCH;
            fetch_stall <= 1'b0;
          end
        end
        default: begin
          state       <= FETCH;
          fetch_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 4'd0, meaning the program counter value loaded on reset.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-004 SHALL have port rom_addr, output, 4, meaning the program ROM address, driven directly from the PC register.
REQ-005 SHALL have port rom_data, input, 16, meaning the program ROM instruction, combinational from rom_addr.
REQ-006 SHALL have port inst_out, output, 16, meaning the registered instruction offered to decode.
REQ-007 SHALL have port inst_pc, output, 4, meaning the address inst_out was fetched from.
REQ-008 SHALL have port inst_valid, output, 1, meaning inst_out/inst_pc hold a valid instruction.
REQ-009 SHALL have port inst_ready, input, 1, meaning decode accepts inst_out this cycle.
REQ-010 SHALL have port br_resolved, input, 1, meaning a one-cycle pulse from execute that the outstanding br is decided.
REQ-011 SHALL have port br_taken, input, 1, meaning the branch outcome, qualified by br_resolved.
REQ-012 SHALL have port fetch_stall, output, 1, meaning high while state is WAIT_BR.

Function
REQ-013 SHALL decode opcode = rom_data[15:12] and target = rom_data[11:8]; jmp = 4'b1000, br = 4'b1100.
REQ-014 SHALL fetch (capture rom_data into inst_out, rom_addr into inst_pc) only when state is FETCH and (!inst_valid or inst_ready).
REQ-015 SHALL set inst_valid on a fetch; clear it on an accepting cycle (inst_valid and inst_ready) with no new fetch.
REQ-016 SHALL hold inst_out, inst_pc and inst_valid stable while inst_valid and !inst_ready.
REQ-017 SHALL give one-cycle latency: an instruction at rom_addr in cycle N appears on inst_out in cycle N+1; sustained throughput is one per cycle.
REQ-018 SHALL fold jmp: on fetching a jmp, PC <= target, inst_valid not set for it, and the jmp is never forwarded.
REQ-019 SHALL forward br to decode, latch br_target <= target and br_fall <= PC+1, and enter WAIT_BR with PC unchanged.
REQ-020 SHALL, for every other opcode, set PC <= PC+1 modulo 16 (15 wraps to 0).
REQ-021 SHALL, in WAIT_BR, perform no fetch and hold PC; on br_resolved, set PC <= br_taken ? br_target : br_fall and return to FETCH.
REQ-022 SHALL ignore br_resolved while in FETCH.
REQ-023 SHALL let the forwarded br drain through the inst_ready handshake while in WAIT_BR, independent of resolution.
REQ-024 SHALL fetch from the new PC in the cycle after br_resolved, giving exactly one bubble cycle.
REQ-025 SHALL allow jmp to its own address (self-loop): PC stays constant and nothing is emitted.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force: PC = RESET_PC (so rom_addr = RESET_PC), inst_out = 0, inst_pc = 0, inst_valid = 0, state = FETCH, fetch_stall = 0, br_target = 0, br_fall = 0.
REQ-027 SHALL discard any in-flight instruction or pending branch when reset is asserted mid-operation, including in WAIT_BR.
REQ-028 SHALL perform its first fetch on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL take OP_JMP, OP_BR, the FETCH/WAIT_BR state encoding and the 4-bit address width from a shared package also used by decode.
REQ-030 SHALL be one flat module with no sub-modules; the program ROM instantiates alongside it, not inside it.

Verification
REQ-031 SHALL cover straight-line fetch: ROM 0..3 = load, subi, add, out; inst_ready = 1 -> inst_pc 0,1,2,3 on consecutive cycles after reset.
REQ-032 SHALL cover jmp folding: 8 = 16'h8300 -> the instruction at 7 is followed by the instruction at 3, and 16'h8300 never appears on inst_out.
REQ-033 SHALL cover taken branch: 4 = 16'hCA00; pulse br_resolved = 1, br_taken = 1 three cycles later -> fetch_stall high three cycles, next inst_pc = 10.
REQ-034 SHALL cover not-taken branch: same stimulus with br_taken = 0 -> next inst_pc = 5.
REQ-035 SHALL cover backpressure: inst_ready = 0 for four cycles mid-stream -> inst_out stable, PC frozen, no instruction lost or duplicated.
REQ-036 SHALL cover reset in WAIT_BR and wrap: reset in WAIT_BR -> rom_addr = 0, inst_valid = 0; straight-line fetch at 15 -> next rom_addr = 0.
